gbuf_p_reader: RTL and testbench

- Drains matrix-product results from global buffer P after the mm controller has written them, and streams them out in address order.
- Sits between buffer P's read port and the host-side output path, e.g. a DMA or AXI-Stream bridge.
- Issues paced reads with fixed read latency and absorbs downstream backpressure through an internal credit-tracked FIFO.
- Uses the same start/valid (done) handshake style as the mm controller.

---
 rtl/gbuf_p_reader.sv | 207 ++++++++++++++++++++
 tb/tb_gbuf_p_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gbuf_p_reader.sv
// Buffer P reader: paced, credit-limited reads of len words streamed out in address order.
// Optional PREAD_STALL_CNT_EN adds stall_cnt_o, counting backpressured cycles during BUSY.
module gbuf_p_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic                  enp_o,
  output logic                  wep_o,
  output logic [ADDR_WIDTH-1:0] addrp_o,
  input  logic [DATA_WIDTH-1:0] datap_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
`ifdef PREAD_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_issue_cnt;
  logic [ADDR_WIDTH-1:0] r_pop_cnt;
  logic [RD_LAT-1:0]     r_pipe_vld;
  logic [RD_LAT-1:0]     r_pipe_last;
  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic                  w_start_busy;
  logic [CW-1:0]         w_inflight;
  logic                  w_credit_ok;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_push;
  logic                  w_push_last;
  logic                  w_pop;
  logic                  w_last_pop;
  logic                  w_empty;
  logic [DATA_WIDTH:0]   w_head;

  assign w_start_busy = (r_state == IDLE) && start_i && (len_i != '0);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_pipe_vld[i]);
    end
  end

  // Every outstanding read owns a FIFO slot, so a push can never find the FIFO full.
  assign w_credit_ok  = ({1'b0, r_count} + {1'b0, w_inflight}) < (CW+1)'(FIFO_DEPTH);
  assign w_issue      = (r_state == BUSY) && (r_issue_cnt < r_len) && w_credit_ok;
  assign w_issue_last = (r_issue_cnt == r_len - ONE_A);
  assign w_push       = r_pipe_vld[RD_LAT-1];
  assign w_push_last  = r_pipe_last[RD_LAT-1];
  assign w_empty      = (r_count == '0);
  assign w_pop        = !w_empty && m_ready_i;
  assign w_last_pop   = w_pop && (r_state == BUSY) && (r_pop_cnt == r_len - ONE_A);
  assign w_head       = r_mem[r_rptr];

  assign enp_o     = w_issue;
  assign wep_o     = 1'b0;
  assign addrp_o   = w_issue ? (r_base + (r_issue_cnt << 4)) : '0;
  assign m_valid_o = !w_empty;
  assign m_data_o  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign m_last_o  = !w_empty && w_head[DATA_WIDTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy_o       = 1'b0;
    valid_o      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = (len_i != '0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        if (w_last_pop) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        valid_o = 1'b1;
        if (!start_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_base      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
    end else begin
      if (r_state == IDLE && start_i) begin
        r_base      <= base_addr_i;
        r_len       <= len_i;
        r_issue_cnt <= '0;
        r_pop_cnt   <= '0;
      end else begin
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt + ONE_A;
        end
        if (w_pop && r_state == BUSY) begin
          r_pop_cnt <= r_pop_cnt + ONE_A;
        end
      end
    end
  end

  // Return pipe mirrors the buffer read latency; clearing it on reset drops late data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue && w_issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_push_last, datap_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PREAD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (w_start_busy) begin
      r_stall_cnt <= '0;
    end else if (r_state == BUSY && m_valid_o && !m_ready_i && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_gbuf_p_reader.sv
// Directed bench for gbuf_p_reader with a one-cycle-latency buffer P model.
// Define PREAD_STALL_CNT_EN to also check the stall counter.
module tb_gbuf_p_reader;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [15:0]  base_addr_i;
  logic [15:0]  len_i;
  logic         busy_o;
  logic         valid_o;
  logic         enp_o;
  logic         wep_o;
  logic [15:0]  addrp_o;
  logic [127:0] datap_i;
  logic         m_valid_o;
  logic         m_ready_i;
  logic [127:0] m_data_o;
  logic         m_last_o;
`ifdef PREAD_STALL_CNT_EN
  logic [31:0]  stall_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  gbuf_p_reader dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .enp_o       (enp_o),
    .wep_o       (wep_o),
    .addrp_o     (addrp_o),
    .datap_i     (datap_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o)
`ifdef PREAD_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  function automatic logic [127:0] memf(input logic [15:0] a);
    return {a, ~a, a ^ 16'h1234, a + 16'h0001, a ^ 16'hA5A5, ~a + 16'h0007, a, 16'hC0DE};
  endfunction

  // Buffer P model: data valid one cycle after the request.
  always @(posedge clk_i) begin
    if (enp_o) datap_i <= memf(addrp_o);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [15:0] base, input logic [15:0] len);
    base_addr_i = base;
    len_i       = len;
    start_i     = 1'b1;
    tick;
    start_i     = 1'b0;
  endtask

  // Consume words until DONE (bounded); check data, last flag and word count.
  task automatic collect(input logic [15:0] base, input int n, input string tag);
    int k = 0;
    for (int c = 0; c < 200 && !valid_o; c++) begin
      if (m_valid_o && m_ready_i) begin
        chk({tag, "_data"}, m_data_o, memf(base + 16'(k * 16)));
        chk({tag, "_last"}, 128'(m_last_o), 128'(k == n - 1));
        $display("%s word %0d data=%0h last=%0b", tag, k, m_data_o, m_last_o);
        k++;
      end
      tick;
    end
    chk({tag, "_count"}, 128'(k), 128'(n));
    chk({tag, "_done"}, 128'(valid_o), 128'd1);
  endtask

  initial begin
    int n_iss;
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    len_i       = '0;
    m_ready_i   = 1'b1;
    datap_i     = '0;
    tick;
    tick;
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_valid", 128'(valid_o), 128'd0);
    chk("rst_enp", 128'(enp_o), 128'd0);
    chk("rst_wep", 128'(wep_o), 128'd0);
    chk("rst_addr", 128'(addrp_o), 128'd0);
    chk("rst_mvalid", 128'(m_valid_o), 128'd0);
    chk("rst_mdata", m_data_o, 128'd0);
    rst_ni = 1'b1;
    tick;

    // Basic read, cycle-exact
    start_job(16'h0100, 16'd4);
    chk("b1_busy", 128'(busy_o), 128'd1);
    chk("b1_enp", 128'(enp_o), 128'd1);
    chk("b1_addr", 128'(addrp_o), 128'h0100);
    chk("b1_mvalid", 128'(m_valid_o), 128'd0);
    tick;
    chk("b2_enp", 128'(enp_o), 128'd1);
    chk("b2_addr", 128'(addrp_o), 128'h0110);
    chk("b2_mvalid", 128'(m_valid_o), 128'd0);
    tick;
    chk("b3_addr", 128'(addrp_o), 128'h0120);
    chk("b3_mvalid", 128'(m_valid_o), 128'd1);
    chk("b3_data", m_data_o, memf(16'h0100));
    chk("b3_last", 128'(m_last_o), 128'd0);
    tick;
    chk("b4_enp", 128'(enp_o), 128'd1);
    chk("b4_addr", 128'(addrp_o), 128'h0130);
    chk("b4_data", m_data_o, memf(16'h0110));
    tick;
    chk("b5_enp", 128'(enp_o), 128'd0);
    chk("b5_data", m_data_o, memf(16'h0120));
    chk("b5_last", 128'(m_last_o), 128'd0);
    tick;
    chk("b6_mvalid", 128'(m_valid_o), 128'd1);
    chk("b6_data", m_data_o, memf(16'h0130));
    chk("b6_last", 128'(m_last_o), 128'd1);
    chk("b6_busy", 128'(busy_o), 128'd1);
    tick;
    chk("b7_valid", 128'(valid_o), 128'd1);
    chk("b7_busy", 128'(busy_o), 128'd0);
    chk("b7_mvalid", 128'(m_valid_o), 128'd0);
    tick;
    chk("b8_idle", 128'(valid_o), 128'd0);
    $display("basic read done");

    // Zero length
    start_job(16'h0700, 16'd0);
    chk("z1_valid", 128'(valid_o), 128'd1);
    chk("z1_busy", 128'(busy_o), 128'd0);
    chk("z1_enp", 128'(enp_o), 128'd0);
    chk("z1_mvalid", 128'(m_valid_o), 128'd0);
    tick;
    chk("z2_idle", 128'(valid_o), 128'd0);
    chk("z2_enp", 128'(enp_o), 128'd0);
    $display("zero length done");

    // Address wrap
    start_job(16'hFFF0, 16'd2);
    chk("w1_addr", 128'(addrp_o), 128'hFFF0);
    tick;
    chk("w2_enp", 128'(enp_o), 128'd1);
    chk("w2_addr", 128'(addrp_o), 128'h0000);
    collect(16'hFFF0, 2, "wrap");
    tick;

    // Backpressure: ready low for cycles 1..12, words valid from cycle 3
    m_ready_i = 1'b0;
    n_iss = 0;
    start_job(16'h0200, 16'd8);
    for (int i = 1; i <= 12; i++) begin
      if (enp_o) n_iss++;
      if (i >= 3) begin
        chk("bp_hold_valid", 128'(m_valid_o), 128'd1);
        chk("bp_hold_data", m_data_o, memf(16'h0200));
        chk("bp_hold_last", 128'(m_last_o), 128'd0);
      end
      tick;
    end
    chk("bp_issues", 128'(n_iss), 128'd4);
    $display("backpressure issues while stalled=%0d", n_iss);
    m_ready_i = 1'b1;
    collect(16'h0200, 8, "bp");
`ifdef PREAD_STALL_CNT_EN
    chk("bp_stall_cnt", 128'(stall_cnt_o), 128'd10);
`endif
    tick;

    // Start pulsed during BUSY is ignored; start held in DONE keeps DONE
    start_job(16'h0500, 16'd5);
    base_addr_i = 16'h0000;
    len_i       = 16'd2;
    start_i     = 1'b1;
    tick;
    start_i     = 1'b0;
    collect(16'h0500, 5, "sh");
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("sh_hold_valid", 128'(valid_o), 128'd1);
      chk("sh_hold_busy", 128'(busy_o), 128'd0);
      chk("sh_hold_enp", 128'(enp_o), 128'd0);
    end
    start_i = 1'b0;
    tick;
    chk("sh_idle_valid", 128'(valid_o), 128'd0);
    chk("sh_idle_busy", 128'(busy_o), 128'd0);

    // Reset mid-operation after two pops
    start_job(16'h0300, 16'd6);
    tick;
    tick;
    chk("mr_w0", m_data_o, memf(16'h0300));
    tick;
    chk("mr_w1", m_data_o, memf(16'h0310));
    tick;
    rst_ni = 1'b0;
    tick;
    chk("mr_busy", 128'(busy_o), 128'd0);
    chk("mr_valid", 128'(valid_o), 128'd0);
    chk("mr_enp", 128'(enp_o), 128'd0);
    chk("mr_addr", 128'(addrp_o), 128'd0);
    chk("mr_mvalid", 128'(m_valid_o), 128'd0);
    chk("mr_mdata", m_data_o, 128'd0);
    chk("mr_mlast", 128'(m_last_o), 128'd0);
    rst_ni = 1'b1;
    tick;
    chk("mr_late_mvalid", 128'(m_valid_o), 128'd0);
    chk("mr_late_busy", 128'(busy_o), 128'd0);
    start_job(16'h0400, 16'd3);
    collect(16'h0400, 3, "mr_after");
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
